// File: rtl/wrap_add_sub.sv
// wrap_add_sub: two-stage pipelined add/subtract with an optional
// modulo-MODULUS wrap. Stage 1 forms the raw WIDTH+1 bit sum/difference.
// Stage 2 applies the single modulo correction and derives the flags.
// Valid/ready handshakes on both ends, plus a synchronous flush.
module wrap_add_sub #(
  parameter int WIDTH   = 5,
  parameter int MODULUS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             wrap_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             wrapped
);

  // MODULUS may equal 2**WIDTH, so it needs one extra bit
  localparam logic [WIDTH:0] ModVal = (WIDTH+1)'(MODULUS);

  logic             s1Valid_q, s1Valid_d;
  logic [WIDTH:0]   raw_q, raw_d;
  logic             op_q, op_d;
  logic             wrapEn_q, wrapEn_d;
  logic             aSign_q, aSign_d;
  logic             bSign_q, bSign_d;

  logic             s2Valid_q, s2Valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             wrapped_q, wrapped_d;

  logic             s2Advance;
  logic [WIDTH:0]   bTerm;
  logic [WIDTH-1:0] rawMinusMod;
  logic [WIDTH-1:0] rawPlusMod;
  logic [WIDTH-1:0] resultCalc;
  logic             carryCalc;
  logic             overflowCalc;
  logic             wrappedCalc;

  // Stage 2 can take new content when it is empty or its result leaves now;
  // stage 1 frees up under the same condition, and flush blocks acceptance
  assign s2Advance = !s2Valid_q || out_ready;
  assign in_ready  = !flush && (!s1Valid_q || s2Advance);

  // Subtraction is a + ~b + 1; bit WIDTH of the raw value is then "no borrow"
  assign bTerm = op ? {1'b0, ~b} : {1'b0, b};

  // Low-bit arithmetic is enough for the corrections: results are mod 2**WIDTH
  assign rawMinusMod = raw_q[WIDTH-1:0] - ModVal[WIDTH-1:0];
  assign rawPlusMod  = raw_q[WIDTH-1:0] + ModVal[WIDTH-1:0];

  // Stage 1 next state: capture a new operation whenever the stage is free
  always_comb begin
    s1Valid_d = s1Valid_q;
    raw_d     = raw_q;
    op_d      = op_q;
    wrapEn_d  = wrapEn_q;
    aSign_d   = aSign_q;
    bSign_d   = bSign_q;
    if (flush) begin
      s1Valid_d = 1'b0;
    end else if (in_ready) begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        raw_d    = {1'b0, a} + bTerm + {{WIDTH{1'b0}}, op};
        op_d     = op;
        wrapEn_d = wrap_en;
        aSign_d  = a[WIDTH-1];
        bSign_d  = b[WIDTH-1];
      end
    end
  end

  // Result and flags from the stage 1 raw value; the wrap is applied at most once
  always_comb begin
    resultCalc  = raw_q[WIDTH-1:0];
    wrappedCalc = 1'b0;
    carryCalc   = raw_q[WIDTH];
    if (op_q) begin
      overflowCalc = (aSign_q != bSign_q) && (raw_q[WIDTH-1] != aSign_q);
    end else begin
      overflowCalc = (aSign_q == bSign_q) && (raw_q[WIDTH-1] != aSign_q);
    end
    if (wrapEn_q) begin
      if (!op_q) begin
        if (raw_q >= ModVal) begin
          resultCalc  = rawMinusMod;
          wrappedCalc = 1'b1;
        end
      end else if (!raw_q[WIDTH]) begin
        resultCalc  = rawPlusMod;
        wrappedCalc = 1'b1;
      end
    end
  end

  // Stage 2 next state: load from stage 1 when advancing, otherwise hold
  always_comb begin
    s2Valid_d  = s2Valid_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    wrapped_d  = wrapped_q;
    if (flush) begin
      s2Valid_d = 1'b0;
    end else if (s2Advance) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        result_d   = resultCalc;
        carry_d    = carryCalc;
        overflow_d = overflowCalc;
        wrapped_d  = wrappedCalc;
      end
    end
  end

  // Pipeline registers; reset empties both stages and zeroes the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      raw_q      <= '0;
      op_q       <= 1'b0;
      wrapEn_q   <= 1'b0;
      aSign_q    <= 1'b0;
      bSign_q    <= 1'b0;
      s2Valid_q  <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      raw_q      <= raw_d;
      op_q       <= op_d;
      wrapEn_q   <= wrapEn_d;
      aSign_q    <= aSign_d;
      bSign_q    <= bSign_d;
      s2Valid_q  <= s2Valid_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      wrapped_q  <= wrapped_d;
    end
  end

  assign out_valid = s2Valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_wrap_add_sub.sv
// tb_wrap_add_sub: drives two instances (MODULUS 32 and MODULUS 20) with the
// same stimulus and compares them against a plain-arithmetic reference model.
module tb_wrap_add_sub;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [4:0] a;
  logic [4:0] b;
  logic       op;
  logic       wrap_en;
  logic       out_ready;

  logic       in_ready, out_valid, carry, overflow, wrapped;
  logic [4:0] result;
  logic       in_ready20, out_valid20, carry20, overflow20, wrapped20;
  logic [4:0] result20;

  typedef struct {
    int         stamp;
    logic [7:0] e32;
    logic [7:0] e20;
  } item_t;

  item_t sbQ[$];
  int    checkCount = 0;
  int    passCount  = 0;
  int    negCount   = 0;
  int    xferCount  = 0;
  bit    expReady;
  bit    expValid;

  wrap_add_sub dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .wrap_en(wrap_en), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .wrapped(wrapped)
  );

  wrap_add_sub #(.WIDTH(5), .MODULUS(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready20),
    .a(a), .b(b), .op(op), .wrap_en(wrap_en), .out_valid(out_valid20), .out_ready(out_ready),
    .result(result20), .carry(carry20), .overflow(overflow20), .wrapped(wrapped20)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    else
      passCount++;
  endtask

  // Reference: {result[4:0], carry, overflow, wrapped} for a 5-bit datapath
  function automatic logic [7:0] modelOp(int av, int bv, bit opv, bit wev, int mod);
    int raw, low, sa, sb, sr, res;
    bit c, ov, w;
    if (!opv) begin
      raw = av + bv;
      c   = (raw >= 32);
    end else begin
      raw = av - bv;
      c   = (av >= bv);
    end
    low = ((raw % 32) + 32) % 32;
    sa  = (av >= 16) ? av - 32 : av;
    sb  = (bv >= 16) ? bv - 32 : bv;
    sr  = opv ? sa - sb : sa + sb;
    ov  = (sr > 15) || (sr < -16);
    res = low;
    w   = 1'b0;
    if (wev) begin
      if (!opv && raw >= mod) begin
        res = (raw - mod) % 32;
        w   = 1'b1;
      end else if (opv && av < bv) begin
        res = (((raw + mod) % 32) + 32) % 32;
        w   = 1'b1;
      end
    end
    return {res[4:0], c, ov, w};
  endfunction

  // Scoreboard: every accepted op must appear exactly 2 edges later (or after
  // backpressure), in order, unless a flush or reset discards it
  always @(negedge clk) begin
    item_t it;
    if (!rst_n) begin
      sbQ.delete();
    end else begin
      negCount++;
      expReady = !flush && (sbQ.size() < 2 || out_ready);
      expValid = (sbQ.size() > 0) && (negCount - sbQ[0].stamp >= 2);
      checkOutput("inReady", in_ready, expReady);
      checkOutput("inReady20", in_ready20, expReady);
      checkOutput("outValid", out_valid, expValid);
      checkOutput("outValid20", out_valid20, expValid);
      if (expValid) begin
        checkOutput("data32", {result, carry, overflow, wrapped}, sbQ[0].e32);
        checkOutput("data20", {result20, carry20, overflow20, wrapped20}, sbQ[0].e20);
        if (out_ready && !flush) begin
          void'(sbQ.pop_front());
          xferCount++;
        end
      end
      if (in_valid && in_ready) begin
        it.stamp = negCount;
        it.e32   = modelOp(int'(a), int'(b), op, wrap_en, 32);
        it.e20   = modelOp(int'(a), int'(b), op, wrap_en, 20);
        sbQ.push_back(it);
      end
      if (flush) sbQ.delete();
    end
  end

  // One clock: sample acceptance mid-cycle, return just after the rising edge
  task automatic applyStimulus(output bit accepted);
    @(negedge clk);
    accepted = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  // Single op with out_ready=1: checks exact 2-cycle latency and known values
  task automatic runDirected(input string tag, input logic [4:0] av, input logic [4:0] bv,
                             input bit opv, input bit wev, input logic [7:0] exp32,
                             input logic [7:0] exp20);
    bit acc;
    a = av; b = bv; op = opv; wrap_en = wev; in_valid = 1'b1; out_ready = 1'b1;
    applyStimulus(acc);
    checkOutput({tag, "_accept"}, 32'(acc), 1);
    in_valid = 1'b0;
    checkOutput({tag, "_lat1"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid"}, 32'(out_valid), 1);
    checkOutput({tag, "_d32"}, {result, carry, overflow, wrapped}, exp32);
    checkOutput({tag, "_d20"}, {result20, carry20, overflow20, wrapped20}, exp20);
    @(posedge clk); #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_outValid"}, 32'(out_valid), 0);
    checkOutput({tag, "_data32"}, {result, carry, overflow, wrapped}, 0);
    checkOutput({tag, "_data20"}, {result20, carry20, overflow20, wrapped20}, 0);
    checkOutput({tag, "_inReady"}, 32'(in_ready), 1);
  endtask

  // Fill both stages with out_ready held low
  task automatic fillPipe();
    bit acc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      a = 5'($urandom); b = 5'($urandom); op = 1'($urandom); wrap_en = 1'($urandom);
      applyStimulus(acc);
    end
  endtask

  initial begin
    bit acc;
    int k;
    int xferBase;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    op = 1'b0; wrap_en = 1'b0; out_ready = 1'b1;
    #1;
    checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases: {result, carry, overflow, wrapped}
    runDirected("sub",       5'd5,  5'd3, 1'b1, 1'b0, {5'd2,  1'b1, 1'b0, 1'b0}, {5'd2,  1'b1, 1'b0, 1'b0});
    runDirected("borrow",    5'd3,  5'd5, 1'b1, 1'b0, {5'd30, 1'b0, 1'b0, 1'b0}, {5'd30, 1'b0, 1'b0, 1'b0});
    runDirected("borrowW",   5'd3,  5'd5, 1'b1, 1'b1, {5'd30, 1'b0, 1'b0, 1'b1}, {5'd18, 1'b0, 1'b0, 1'b1});
    runDirected("addWrap",   5'd18, 5'd5, 1'b0, 1'b1, {5'd23, 1'b0, 1'b0, 1'b0}, {5'd3,  1'b0, 1'b0, 1'b1});
    runDirected("subWrap",   5'd2,  5'd5, 1'b1, 1'b1, {5'd29, 1'b0, 1'b0, 1'b1}, {5'd17, 1'b0, 1'b0, 1'b1});
    runDirected("ovfAdd",    5'd15, 5'd1, 1'b0, 1'b0, {5'd16, 1'b0, 1'b1, 1'b0}, {5'd16, 1'b0, 1'b1, 1'b0});
    runDirected("carryAdd",  5'd31, 5'd1, 1'b0, 1'b0, {5'd0,  1'b1, 1'b0, 1'b0}, {5'd0,  1'b1, 1'b0, 1'b0});

    // Backpressure: only two ops fit, then results drain one per cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    k = 0;
    a = 5'($urandom); b = 5'($urandom); op = 1'($urandom); wrap_en = 1'($urandom);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(acc);
      if (acc) begin
        k++;
        a = 5'($urandom); b = 5'($urandom); op = 1'($urandom); wrap_en = 1'($urandom);
      end
    end
    checkOutput("bpAccepted", k, 2);
    checkOutput("bpInReady", 32'(in_ready), 0);
    out_ready = 1'b1;
    xferBase  = xferCount;
    for (int c = 0; c < 4; c++) begin
      in_valid = (k < 4);
      applyStimulus(acc);
      if (acc) begin
        k++;
        a = 5'($urandom); b = 5'($urandom); op = 1'($urandom); wrap_en = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    checkOutput("bpTotal", k, 4);
    checkOutput("bpXfers", xferCount - xferBase, 4);

    // Flush with two ops in flight and a new op offered
    fillPipe();
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    checkOutput("flushInReady", 32'(in_ready), 0);
    applyStimulus(acc);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checkOutput("flushOutValid", 32'(out_valid), 0);
    checkOutput("flushOutValid20", 32'(out_valid20), 0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("flushNoEmerge", 32'(out_valid), 0);

    // Asynchronous reset with two ops in flight
    fillPipe();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkResetOutputs("midReset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runDirected("afterReset", 5'd5, 5'd3, 1'b1, 1'b0, {5'd2, 1'b1, 1'b0, 1'b0}, {5'd2, 1'b1, 1'b0, 1'b0});

    // Randomized traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 5'($urandom);
      b         = 5'($urandom);
      op        = 1'($urandom);
      wrap_en   = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("drained", sbQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
